align_shift_sequencer: RTL

- Multi-cycle alignment controller for the FP add/sub path.
- Accepts two operands (exponent plus mantissa with hidden bit), computes the absolute exponent difference and swaps so the larger-exponent operand is "Large".
- Right-shifts the smaller mantissa by at most StepSize bits per cycle, accumulating a sticky bit.
- Hands the aligned pair to the significand adder over a valid/ready handshake.

---
 rtl/align_shift_sequencer.sv | 104 ++++++++++
 1 files changed

// File: rtl/align_shift_sequencer.sv
// Multi-cycle exponent alignment for the FP add/sub path: swaps operands so the
// larger exponent is "Large", then right-shifts the smaller mantissa StepSize bits/cycle with sticky.
module align_shift_sequencer #(
  parameter int ExponentSize = 8,
  parameter int MantissaSize = 24,
  parameter int StepSize     = 4,
  parameter int MaxShift     = 27
) (
  input  logic                    Clk,
  input  logic                    nReset,
  input  logic                    InValid,
  output logic                    InReady,
  input  logic [ExponentSize-1:0] Exponent1,
  input  logic [ExponentSize-1:0] Exponent2,
  input  logic [MantissaSize-1:0] Mantissa1,
  input  logic [MantissaSize-1:0] Mantissa2,
  output logic                    OutValid,
  input  logic                    OutReady,
  output logic [ExponentSize-1:0] LargeExponent,
  output logic [MantissaSize+2:0] AlignedLarge,
  output logic [MantissaSize+2:0] AlignedSmall,
  output logic                    Swap,
  output logic [4:0]              ShiftCount,
  output logic                    Busy
);
  localparam int AW = MantissaSize + 3;
  localparam logic [ExponentSize:0] MaxShiftE = (ExponentSize+1)'(MaxShift);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state;

  logic [4:0]              remaining;
  logic                    swapNext;
  logic [ExponentSize:0]   diff;
  logic [4:0]              dSat;
  logic [4:0]              step;
  logic [AW-1:0]           stickyMask;
  logic [AW-1:0]           shifted;
  logic [AW-1:0]           nextSmall;

  assign InReady = (state == IDLE);

  // Difference is one bit wider than the exponents so it can never wrap.
  always_comb begin
    swapNext = (Exponent2 > Exponent1);
    diff = swapNext ? ({1'b0, Exponent2} - {1'b0, Exponent1})
                    : ({1'b0, Exponent1} - {1'b0, Exponent2});
    dSat = (diff > MaxShiftE) ? 5'(MaxShift) : diff[4:0];
  end

  // One shift step: bits falling off the bottom (including the old sticky) fold into bit 0.
  always_comb begin
    step       = (remaining > 5'(StepSize)) ? 5'(StepSize) : remaining;
    stickyMask = ~({AW{1'b1}} << step);
    shifted    = AlignedSmall >> step;
    nextSmall  = {shifted[AW-1:1], shifted[0] | (|(AlignedSmall & stickyMask))};
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state         <= IDLE;
      remaining     <= '0;
      OutValid      <= 1'b0;
      LargeExponent <= '0;
      AlignedLarge  <= '0;
      AlignedSmall  <= '0;
      Swap          <= 1'b0;
      ShiftCount    <= '0;
      Busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (InValid) begin
          Swap          <= swapNext;
          LargeExponent <= swapNext ? Exponent2 : Exponent1;
          AlignedLarge  <= swapNext ? {Mantissa2, 3'b000} : {Mantissa1, 3'b000};
          AlignedSmall  <= swapNext ? {Mantissa1, 3'b000} : {Mantissa2, 3'b000};
          ShiftCount    <= dSat;
          remaining     <= dSat;
          Busy          <= 1'b1;
          if (dSat != 5'd0) begin
            state <= SHIFT;
          end else begin
            state    <= DONE;
            OutValid <= 1'b1;
          end
        end
        SHIFT: begin
          AlignedSmall <= nextSmall;
          remaining    <= remaining - step;
          if (remaining == step) begin
            state    <= DONE;
            OutValid <= 1'b1;
          end
        end
        DONE: if (OutReady) begin
          state    <= IDLE;
          OutValid <= 1'b0;
          Busy     <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
